pc_fetch_unit: RTL

Holds the architectural PC and sequences instruction fetch for the accumulator processor. Each fetched instruction is presented to decode, and the PC then advances.
- Drives the PC into the PC+2 adder stage (PCIN) and consumes that adder's registered PCOUT as the sequential next-PC.
- Branch/jump redirects from the control unit override the sequential path.
- Sits between the PC+2 adder, instruction memory and the decode/control stage.

---
 rtl/pc_fetch_pkg.sv | 19 +
 rtl/pc_fetch_unit_fetch_timeout_ctr.sv | 52 +++++
 rtl/pc_fetch_unit.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the PC/fetch sequencer of the accumulator processor.
package pc_fetch_pkg;

    localparam int PC_W = 16;
    localparam logic [PC_W-1:0] DEFAULT_RESET_VECTOR = 16'h0000;
    localparam logic [PC_W-1:0] INSTR_STEP = 16'd2;

    typedef enum logic [1:0] {
        S_BOOT  = 2'b00,
        S_FETCH = 2'b01,
        S_ISSUE = 2'b10
    } fetch_state_e;

    // Round a branch target down to an instruction boundary.
    function automatic logic [PC_W-1:0] force_even(input logic [PC_W-1:0] target);
        return target & ~(INSTR_STEP - 16'd1);
    endfunction

endpackage

// File: rtl/pc_fetch_unit_fetch_timeout_ctr.sv
// Counts consecutive unacknowledged fetch cycles; raises a sticky flag at LIMIT.
module fetch_timeout_ctr #(
    parameter int unsigned LIMIT = 8
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic clr,
    input  logic en,
    output logic tc,
    output logic flag
);

    localparam logic [7:0] LIMIT_C = 8'(LIMIT);

    logic [7:0] cnt_r;
    logic [7:0] cnt_nxt_s;
    logic       flag_r;
    logic       flag_nxt_s;

    assign tc   = (cnt_r == LIMIT_C);
    assign flag = flag_r;

    // Next count saturates at LIMIT; the flag latches on the edge the count reaches it.
    always_comb begin
        cnt_nxt_s  = cnt_r;
        flag_nxt_s = flag_r;
        if (clr) begin
            cnt_nxt_s = 8'd0;
        end else if (en && !tc) begin
            cnt_nxt_s = cnt_r + 8'd1;
        end else begin
            cnt_nxt_s = cnt_r;
        end
        if (!clr && en && (cnt_r == (LIMIT_C - 8'd1))) begin
            flag_nxt_s = 1'b1;
        end else begin
            flag_nxt_s = flag_r;
        end
    end

    // Counter and sticky flag registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_r  <= 8'd0;
            flag_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_nxt_s;
            flag_r <= flag_nxt_s;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC holder and instruction fetch sequencer (BOOT -> FETCH -> ISSUE).
// Optional macro BRANCH_ALIGN_CHECK_EN: evens odd branch targets and adds sticky MISALIGN.
module pc_fetch_unit
    import pc_fetch_pkg::*;
#(
    parameter logic [15:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter int unsigned ACK_TIMEOUT  = 8
) (
    input  logic        CLK,
    input  logic        RST_N,
    output logic [15:0] PC,
    input  logic [15:0] PCPLUS2,
    output logic        IMEM_REQ,
    output logic [15:0] IMEM_ADDR,
    input  logic        IMEM_ACK,
    input  logic [15:0] IMEM_DATA,
    output logic [15:0] IR,
    output logic        IR_VALID,
    input  logic        IR_TAKEN,
    input  logic        STALL,
    input  logic        REDIRECT,
    input  logic [15:0] REDIRECT_PC,
    output logic        FETCH_ERR
`ifdef BRANCH_ALIGN_CHECK_EN
    ,
    output logic        MISALIGN
`endif
);

    fetch_state_e state_r;
    fetch_state_e state_nxt_s;
    logic [15:0]  pc_r;
    logic [15:0]  pc_nxt_s;
    logic [15:0]  ir_r;
    logic [15:0]  ir_nxt_s;
    logic         ir_valid_r;
    logic         ir_valid_nxt_s;
    logic         req_r;
    logic         req_nxt_s;
    logic         redir_pend_r;
    logic         redir_pend_nxt_s;
    logic [15:0]  redir_pc_r;
    logic [15:0]  redir_pc_nxt_s;
    logic [15:0]  redir_tgt_s;
    logic         ack_s;
    logic         to_en_s;
    logic         to_clr_s;
    logic         timeout_tc_unused_s;

`ifdef BRANCH_ALIGN_CHECK_EN
    logic misalign_r;

    assign redir_tgt_s = force_even(REDIRECT_PC);
    assign MISALIGN    = misalign_r;

    // Sticky record of any odd branch target accepted by the latch.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            misalign_r <= 1'b0;
        end else begin
            misalign_r <= misalign_r | (REDIRECT && (state_r != S_BOOT) && REDIRECT_PC[0]);
        end
    end
`else
    assign redir_tgt_s = REDIRECT_PC;
`endif

    // An ACK only counts while a request is actually on the bus.
    assign ack_s     = (state_r == S_FETCH) && req_r && IMEM_ACK;
    assign to_en_s   = (state_r == S_FETCH) && req_r && !IMEM_ACK;
    assign to_clr_s  = (state_r != S_FETCH) || ack_s;

    assign PC        = pc_r;
    assign IMEM_ADDR = pc_r;
    assign IMEM_REQ  = req_r;
    assign IR        = ir_r;
    assign IR_VALID  = ir_valid_r;

    fetch_timeout_ctr #(
        .LIMIT (ACK_TIMEOUT)
    ) u_timeout (
        .CLK   (CLK),
        .RST_N (RST_N),
        .clr   (to_clr_s),
        .en    (to_en_s),
        .tc    (timeout_tc_unused_s),
        .flag  (FETCH_ERR)
    );

    // Next-state, PC selection, IR capture and redirect latch.
    always_comb begin
        state_nxt_s      = state_r;
        pc_nxt_s         = pc_r;
        ir_nxt_s         = ir_r;
        ir_valid_nxt_s   = ir_valid_r;
        req_nxt_s        = req_r;
        redir_pend_nxt_s = redir_pend_r;
        redir_pc_nxt_s   = redir_pc_r;

        if (REDIRECT && (state_r != S_BOOT)) begin
            redir_pend_nxt_s = 1'b1;
            redir_pc_nxt_s   = redir_tgt_s;
        end else begin
            redir_pend_nxt_s = redir_pend_r;
            redir_pc_nxt_s   = redir_pc_r;
        end

        case (state_r)
            S_BOOT: begin
                state_nxt_s = S_FETCH;
                req_nxt_s   = 1'b1;
            end
            S_FETCH: begin
                if (ack_s) begin
                    req_nxt_s = 1'b0;
                    if (redir_pend_r) begin
                        // Stale fetch: drop the data and refetch from the target after a settle cycle.
                        pc_nxt_s         = REDIRECT ? redir_tgt_s : redir_pc_r;
                        redir_pend_nxt_s = 1'b0;
                    end else begin
                        ir_nxt_s       = IMEM_DATA;
                        ir_valid_nxt_s = 1'b1;
                        state_nxt_s    = S_ISSUE;
                    end
                end else begin
                    req_nxt_s = 1'b1;
                end
            end
            S_ISSUE: begin
                if (IR_TAKEN && !STALL) begin
                    ir_valid_nxt_s   = 1'b0;
                    state_nxt_s      = S_FETCH;
                    req_nxt_s        = 1'b1;
                    redir_pend_nxt_s = 1'b0;
                    if (REDIRECT) begin
                        pc_nxt_s = redir_tgt_s;
                    end else if (redir_pend_r) begin
                        pc_nxt_s = redir_pc_r;
                    end else begin
                        pc_nxt_s = PCPLUS2;
                    end
                end else begin
                    state_nxt_s = S_ISSUE;
                end
            end
            default: begin
                state_nxt_s      = S_BOOT;
                req_nxt_s        = 1'b0;
                ir_valid_nxt_s   = 1'b0;
                redir_pend_nxt_s = 1'b0;
            end
        endcase
    end

    // Architectural state registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r      <= S_BOOT;
            pc_r         <= RESET_VECTOR;
            ir_r         <= 16'h0000;
            ir_valid_r   <= 1'b0;
            req_r        <= 1'b0;
            redir_pend_r <= 1'b0;
            redir_pc_r   <= 16'h0000;
        end else begin
            state_r      <= state_nxt_s;
            pc_r         <= pc_nxt_s;
            ir_r         <= ir_nxt_s;
            ir_valid_r   <= ir_valid_nxt_s;
            req_r        <= req_nxt_s;
            redir_pend_r <= redir_pend_nxt_s;
            redir_pc_r   <= redir_pc_nxt_s;
        end
    end

endmodule
